seq_detect_1011: RTL and testbench

Serial pattern detector that consumes the registered bit stream produced by the team's synchronous D flip-flop (`dff_syn`) stage and flags every occurrence of the pattern 1011. A Moore FSM tracks partial matches, emits a one-cycle detection pulse, and a saturating counter tallies detections. Overlapping matches are selectable by parameter. The block sits directly downstream of the flip-flop stage and feeds status/LED logic.

---
 rtl/seq_pkg.sv | 18 +
 rtl/sat_counter.sv | 24 ++
 rtl/seq_detect_1011.sv | 82 ++++++++
 tb/tb_seq_detect_1011.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 serial pattern detector: state encoding,
// state width and default counter width.
package seq_pkg;

   localparam int STATE_W = 3;
   localparam int CNT_W_DEFAULT = 8;

   // Each state is named after how much of "1011" has been seen so far.
   // Encodings 101..111 are not listed here; the FSM sends them to S0.
   typedef enum logic [STATE_W-1:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b010,
      S3 = 3'b011,
      S4 = 3'b100
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
// Once it reaches all-ones it stays there until reset or clear.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   // Reset beats clear, clear beats increment; hold at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {WIDTH{1'b1}})) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/seq_detect_1011.sv
// Moore FSM that detects 1011 in a registered serial bit stream, producing a
// one-cycle registered pulse per hit and a saturating tally of hits.
// OVERLAP selects whether the trailing bits of a hit may start the next match.
module seq_detect_1011
   import seq_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter bit OVERLAP = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               d,
   input  logic               en,
   input  logic               clr,
   output logic               q_det,
   output logic [CNT_W-1:0]   det_cnt,
   output logic [STATE_W-1:0] state
);

   state_t cur_state;
   state_t nxt_state;
   logic   hit;

   // Next-state logic; with en low the state holds, and illegal codes fall back to S0.
   always_comb begin
      nxt_state = cur_state;
      unique case (cur_state)
         S0: if (en) nxt_state = d ? S1 : S0;
         S1: if (en) nxt_state = d ? S1 : S2;
         S2: if (en) nxt_state = d ? S3 : S0;
         S3: if (en) nxt_state = d ? S4 : S2;
         S4: begin
            if (en) begin
               if (d) begin
                  nxt_state = S1;
               end else begin
                  nxt_state = OVERLAP ? S2 : S0;
               end
            end
         end
         default: nxt_state = S0;
      endcase
   end

   // A hit is an enabled edge that lands in S4.
   assign hit = en && (nxt_state == S4);

   // State register: reset first, then clear, then normal advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state <= S0;
      end else if (clr) begin
         cur_state <= S0;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Detection pulse register; a hit coinciding with clear is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_det <= 1'b0;
      end else if (clr) begin
         q_det <= 1'b0;
      end else begin
         q_det <= hit;
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_sat_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (hit),
      .cnt   (det_cnt)
   );

   assign state = cur_state;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Self-checking bench for seq_detect_1011. Two instances share the inputs:
// one overlapping with an 8-bit counter, one non-overlapping with a 2-bit counter.
// Expected outputs come from a pattern-history model of the detector.
module tb_seq_detect_1011;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       d = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;

   logic       q_det_a;
   logic [7:0] det_cnt_a;
   logic [2:0] state_a;
   logic       q_det_b;
   logic [1:0] det_cnt_b;
   logic [2:0] state_b;

   int nAsserts = 0;
   int nFails = 0;

   // Model: last up-to-4 sampled bits (newest in bit 0) and how many are valid.
   logic [3:0] histA, histB;
   int         nA, nB;
   int         stA, stB;
   logic       qA, qB;
   logic [7:0] cA;
   logic [1:0] cB;

   int         pulsesB;
   logic [1:0] satSeq [5];

   // Free-running clock
   always #5 clk = ~clk;

   seq_detect_1011 #(.CNT_W(8), .OVERLAP(1'b1)) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (d),
      .en      (en),
      .clr     (clr),
      .q_det   (q_det_a),
      .det_cnt (det_cnt_a),
      .state   (state_a)
   );

   seq_detect_1011 #(.CNT_W(2), .OVERLAP(1'b0)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (d),
      .en      (en),
      .clr     (clr),
      .q_det   (q_det_b),
      .det_cnt (det_cnt_b),
      .state   (state_b)
   );

   // Progress through "1011" = longest suffix of the history that is a prefix of 1011.
   function automatic int suffixState(input logic [3:0] h, input int n);
      int pat = 11;
      int lim = (n > 4) ? 4 : n;
      for (int k = lim; k >= 1; k--) begin
         int m = (1 << k) - 1;
         if ((int'(h) & m) == (pat >> (4 - k))) return k;
      end
      return 0;
   endfunction

   task automatic modelEdge();
      if (!rst_n || clr) begin
         histA = '0; histB = '0; nA = 0; nB = 0;
         stA = 0; stB = 0; qA = 1'b0; qB = 1'b0; cA = '0; cB = '0;
      end else if (en) begin
         histA = {histA[2:0], d};
         if (nA < 4) nA++;
         stA = suffixState(histA, nA);
         qA = (stA == 4);
         if (qA && cA != 8'hFF) cA = cA + 8'd1;

         histB = {histB[2:0], d};
         if (nB < 4) nB++;
         stB = suffixState(histB, nB);
         qB = (stB == 4);
         if (qB && cB != 2'b11) cB = cB + 2'd1;
         if (qB) nB = 0;
      end else begin
         qA = 1'b0;
         qB = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag);
      nAsserts++;
      assert (state_a === 3'(stA)) else begin nFails++; $error("[TB] FAIL %s state_a got %b want %b", tag, state_a, 3'(stA)); end
      nAsserts++;
      assert (q_det_a === qA) else begin nFails++; $error("[TB] FAIL %s q_det_a got %b want %b", tag, q_det_a, qA); end
      nAsserts++;
      assert (det_cnt_a === cA) else begin nFails++; $error("[TB] FAIL %s det_cnt_a got %0d want %0d", tag, det_cnt_a, cA); end
      nAsserts++;
      assert (state_b === 3'(stB)) else begin nFails++; $error("[TB] FAIL %s state_b got %b want %b", tag, state_b, 3'(stB)); end
      nAsserts++;
      assert (q_det_b === qB) else begin nFails++; $error("[TB] FAIL %s q_det_b got %b want %b", tag, q_det_b, qB); end
      nAsserts++;
      assert (det_cnt_b === cB) else begin nFails++; $error("[TB] FAIL %s det_cnt_b got %0d want %0d", tag, det_cnt_b, cB); end
   endtask

   // Drive one edge's worth of inputs, advance the model on the edge, check 1 ns later.
   task automatic applyStimulus(input logic dv, input logic env, input logic clrv,
                                input logic rstv, input string tag);
      d = dv; en = env; clr = clrv; rst_n = rstv;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   task automatic feed(input logic [7:0] bits, input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) applyStimulus(bits[i], 1'b1, 1'b0, 1'b1, tag);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "reset");
   endtask

   initial begin
      // Reset held two edges with d=1, en=1, then 1,0
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "reset0");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "reset1");
      nAsserts++;
      assert (state_a === 3'b000 && det_cnt_a === 8'd0 && q_det_a === 1'b0)
         else begin nFails++; $error("[TB] FAIL reset_const got state=%b cnt=%0d q=%b want 000/0/0", state_a, det_cnt_a, q_det_a); end
      feed(8'b10, 2, "after_reset");
      nAsserts++;
      assert (state_a === 3'b010) else begin nFails++; $error("[TB] FAIL s2_const got %b want 010", state_a); end

      // Basic hit
      doReset();
      feed(8'b01011, 5, "basic");
      nAsserts++;
      assert (q_det_a === 1'b1 && det_cnt_a === 8'd1)
         else begin nFails++; $error("[TB] FAIL basic_const got q=%b cnt=%0d want 1/1", q_det_a, det_cnt_a); end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, "basic_after");

      // Overlapping stream
      doReset();
      feed(8'b1011011, 7, "overlap");
      nAsserts++;
      assert (det_cnt_a === 8'd2 && det_cnt_b === 2'd1)
         else begin nFails++; $error("[TB] FAIL overlap_const got a=%0d b=%0d want 2/1", det_cnt_a, det_cnt_b); end

      // Enable gap mid-pattern
      doReset();
      feed(8'b101, 3, "gap_pre");
      for (int i = 0; i < 3; i++) applyStimulus(1'(i % 2), 1'b0, 1'b0, 1'b1, "gap_hold");
      nAsserts++;
      assert (state_a === 3'b011) else begin nFails++; $error("[TB] FAIL gap_hold_const got %b want 011", state_a); end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, "gap_resume");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, "gap_en0_after_hit");

      // Clear mid-pattern, reset+clear together, clear on completing edge
      doReset();
      feed(8'b101, 3, "clr_pre");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "clr_mid");
      feed(8'b101, 3, "rstclr_pre");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "rst_and_clr");
      feed(8'b1011, 4, "pre_count");
      feed(8'b101, 3, "clr_done_pre");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "clr_on_hit");
      nAsserts++;
      assert (det_cnt_a === 8'd0 && q_det_a === 1'b0)
         else begin nFails++; $error("[TB] FAIL clr_on_hit_const got cnt=%0d q=%b want 0/0", det_cnt_a, q_det_a); end

      // Saturation of the 2-bit non-overlapping counter
      doReset();
      pulsesB = 0;
      satSeq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int r = 0; r < 5; r++) begin
         for (int i = 3; i >= 0; i--) begin
            logic [3:0] pat;
            pat = 4'b1011;
            applyStimulus(pat[i], 1'b1, 1'b0, 1'b1, "sat");
            if (q_det_b) pulsesB++;
         end
         nAsserts++;
         assert (det_cnt_b === satSeq[r])
            else begin nFails++; $error("[TB] FAIL sat_seq%0d got %0d want %0d", r, det_cnt_b, satSeq[r]); end
      end
      nAsserts++;
      assert (pulsesB == 5) else begin nFails++; $error("[TB] FAIL sat_pulses got %0d want 5", pulsesB); end

      // Randomized traffic against the model
      doReset();
      for (int i = 0; i < 600; i++) begin
         logic rv, cv, ev, dv;
         dv = 1'($urandom_range(0, 1));
         ev = ($urandom_range(0, 9) < 8);
         cv = ($urandom_range(0, 99) < 3);
         rv = !($urandom_range(0, 99) < 2);
         applyStimulus(dv, ev, cv, rv, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
